// File: rtl/fir_da_pkg.sv
// Shared constants and types for the distributed-arithmetic FIR front end.
package fir_da_pkg;

   localparam int TAPS  = 4;
   localparam int SEL_W = 4;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   function automatic int idx_w(input int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

endpackage

// File: rtl/da_tap_shreg.sv
// One tap's bit-serial shift register: parallel load, shift right by one, sync clear.
module da_tap_shreg
   import fir_da_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          load,
   input  logic          shift,
   input  logic [DW-1:0] d,
   output logic          lsb
);

   logic [DW-1:0] sh_q, sh_d;

   // A load on the last-bit cycle must win over the shift so the next word starts intact.
   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = d;
      end else if (shift) begin
         sh_d = {1'b0, sh_q[DW-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign lsb = sh_q[0];

endmodule

// File: rtl/da_bit_serializer.sv
// 4-tap delay line shifted out LSB-first as DA LUT select words.
// Optional macro DA_B2B_EN: accept the next sample on the last-bit cycle (no bubble between words).
module da_bit_serializer
   import fir_da_pkg::*;
#(
   parameter int DW   = 8,
   parameter int TAPS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_data,
   output logic [SEL_W-1:0]     sel,
   output logic                 bit_valid,
   output logic                 bit_first,
   output logic                 bit_last,
   output logic [idx_w(DW)-1:0] bit_idx,
   output logic                 busy
);

   localparam int            IW       = idx_w(DW);
   localparam logic [IW-1:0] LAST_IDX = IW'(DW - 1);

   if (TAPS != fir_da_pkg::TAPS || DW < 2 || DW > 16) begin : g_bad_param
      $error("da_bit_serializer: TAPS must be 4 and DW must be 2..16");
   end

   state_e               state_q, state_d;
   logic [IW-1:0]        cnt_q, cnt_d;
   // tap3 is only ever consumed by its shift register, so only taps 0..2 are kept here.
   logic signed [DW-1:0] hist_q [SEL_W-1];
   logic [DW-1:0]        load_val [SEL_W];
   logic [SEL_W-1:0]     lsb;
   logic                 shifting, last_bit, rdy_state, take;

   logic [SEL_W-1:0]     sel_q;
   logic                 valid_q, first_q, last_q;
   logic [IW-1:0]        idx_q;

   assign shifting = (state_q == SHIFT);
   assign last_bit = shifting && (cnt_q == LAST_IDX);

`ifdef DA_B2B_EN
   assign rdy_state = (state_q == IDLE) || last_bit;
`else
   assign rdy_state = (state_q == IDLE);
`endif

   assign in_ready = rst_n && !clr && rdy_state;
   assign take     = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (take) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (take) begin
               cnt_d = '0;
            end else if (last_bit) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         for (int i = 0; i < SEL_W - 1; i++) begin
            hist_q[i] <= '0;
         end
      end else if (take) begin
         hist_q[0] <= in_data;
         hist_q[1] <= hist_q[0];
         hist_q[2] <= hist_q[1];
      end
   end

   assign load_val[0] = in_data;
   assign load_val[1] = hist_q[0];
   assign load_val[2] = hist_q[1];
   assign load_val[3] = hist_q[2];

   for (genvar k = 0; k < SEL_W; k++) begin : g_tap
      da_tap_shreg #(
         .DW(DW)
      ) u_shreg (
         .clk  (clk),
         .rst_n(rst_n),
         .clr  (clr),
         .load (take),
         .shift(shifting),
         .d    (load_val[k]),
         .lsb  (lsb[k])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         sel_q   <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         sel_q   <= shifting ? lsb : '0;
         valid_q <= shifting;
         first_q <= shifting && (cnt_q == '0);
         last_q  <= last_bit;
         idx_q   <= shifting ? cnt_q : '0;
      end
   end

   assign sel       = sel_q;
   assign bit_valid = valid_q;
   assign bit_first = first_q;
   assign bit_last  = last_q;
   assign bit_idx   = idx_q;
   assign busy      = valid_q;

endmodule
